// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX-stage operand forwarding selects and load-use stall detection.
// Define STALL_CNT_EN to add the saturating 16-bit stall-cycle counter on stall_cnt_o.
module fwd_ctrl_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_rs_i,
   input  logic [4:0]  iss_rt_i,
   input  logic [4:0]  iss_rd_i,
   input  logic        iss_regwrite_i,
   input  logic        iss_memread_i,
   input  logic        flush_i,
   output logic [1:0]  fwdA_sel_o,
   output logic [1:0]  fwdB_sel_o,
   output logic        stall_o
`ifdef STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      SEL_RF     = 2'd0,
      SEL_EX_MEM = 2'd1,
      SEL_MEM_WB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } ex_stage_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
   } wr_stage_t;

   ex_stage_t ex_q;
   ex_stage_t ex_d;
   wr_stage_t mem_q;
   wr_stage_t wb_q;
   logic      load_use;

   // The younger writer (MEM) is checked first so the newest value wins; r0 is never forwarded.
   function automatic fwd_sel_e pick_src(input logic [4:0] src,
                                         input wr_stage_t  mem,
                                         input wr_stage_t  wb);
      if (mem.we && (mem.rd != 5'd0) && (mem.rd == src))
         return SEL_EX_MEM;
      else if (wb.we && (wb.rd != 5'd0) && (wb.rd == src))
         return SEL_MEM_WB;
      return SEL_RF;
   endfunction

   assign fwdA_sel_o = pick_src(ex_q.rs, mem_q, wb_q);
   assign fwdB_sel_o = pick_src(ex_q.rt, mem_q, wb_q);

   assign load_use = iss_valid_i && ex_q.ld && (ex_q.rd != 5'd0) &&
                     ((ex_q.rd == iss_rs_i) || (ex_q.rd == iss_rt_i));
   assign stall_o  = load_use;

   always_comb begin
      // NOTE: ex_d gets a full default first so every path assigns it and no latch is inferred.
      ex_d = '0;
      if (iss_valid_i && !load_use && !flush_i) begin
         ex_d.rs = iss_rs_i;
         ex_d.rt = iss_rt_i;
         ex_d.rd = iss_rd_i;
         ex_d.we = iss_regwrite_i;
         ex_d.ld = iss_memread_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its pre-edge neighbour and the pipe shifts as one.
         ex_q  <= ex_d;
         mem_q <= '{rd: ex_q.rd, we: ex_q.we};
         wb_q  <= mem_q;
      end
   end

`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         stall_cnt_q <= '0;
      else if (load_use && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb_fwd_ctrl_unit: directed and random checks of fwd_ctrl_unit against an in-flight-list model.
// Honours STALL_CNT_EN the same way the design does.
module tb_fwd_ctrl_unit;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } ins_t;

   localparam ins_t BUB = '0;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        iss_valid_i, iss_regwrite_i, iss_memread_i, flush_i;
   logic [4:0]  iss_rs_i, iss_rt_i, iss_rd_i;
   logic [1:0]  fwdA_sel_o, fwdB_sel_o;
   logic        stall_o;
`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt_o;
   int          exp_cnt;
`endif

   int   tests = 0;
   int   fails = 0;
   ins_t pipe[$];      // pipe[0] = in EX, pipe[1] = one older (MEM), pipe[2] = two older (WB)
   ins_t cur_ins;
   logic cur_fl;
   ins_t nop;
   logic held;

   fwd_ctrl_unit dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .iss_valid_i    (iss_valid_i),
      .iss_rs_i       (iss_rs_i),
      .iss_rt_i       (iss_rt_i),
      .iss_rd_i       (iss_rd_i),
      .iss_regwrite_i (iss_regwrite_i),
      .iss_memread_i  (iss_memread_i),
      .flush_i        (flush_i),
      .fwdA_sel_o     (fwdA_sel_o),
      .fwdB_sel_o     (fwdB_sel_o),
      .stall_o        (stall_o)
`ifdef STALL_CNT_EN
      ,
      .stall_cnt_o    (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   function automatic ins_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic we, input logic ld);
      ins_t i;
      i.v = v; i.rs = rs; i.rt = rt; i.rd = rd; i.we = we; i.ld = ld;
      return i;
   endfunction

   // Select code = how many stages back the youngest real writer of src sits (1 or 2), else 0.
   function automatic logic [1:0] exp_sel(input logic [4:0] src);
      for (int d = 1; d <= 2; d++)
         if (pipe[d].we && pipe[d].rd != 5'd0 && pipe[d].rd == src)
            return 2'(d);
      return 2'd0;
   endfunction

   function automatic logic exp_stall();
      return cur_ins.v && pipe[0].ld && pipe[0].rd != 5'd0 &&
             (pipe[0].rd == cur_ins.rs || pipe[0].rd == cur_ins.rt);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pipe = '{BUB, BUB, BUB};
`ifdef STALL_CNT_EN
      exp_cnt = 0;
`endif
   endtask

   task automatic drive(input ins_t i, input logic fl);
      cur_ins        = i;
      cur_fl         = fl;
      iss_valid_i    = i.v;
      iss_rs_i       = i.rs;
      iss_rt_i       = i.rt;
      iss_rd_i       = i.rd;
      iss_regwrite_i = i.we;
      iss_memread_i  = i.ld;
      flush_i        = fl;
      #2;
   endtask

   task automatic model_check(input string tag);
      check({tag, "_fwdA"},  {14'd0, fwdA_sel_o}, {14'd0, exp_sel(pipe[0].rs)});
      check({tag, "_fwdB"},  {14'd0, fwdB_sel_o}, {14'd0, exp_sel(pipe[0].rt)});
      check({tag, "_stall"}, {15'd0, stall_o},    {15'd0, exp_stall()});
`ifdef STALL_CNT_EN
      check({tag, "_cnt"},   stall_cnt_o,         16'(exp_cnt));
`endif
   endtask

   task automatic tick();
      logic st;
      ins_t enter;
      st    = exp_stall();
      enter = (cur_ins.v && !st && !cur_fl) ? cur_ins : BUB;
      @(posedge clk_i);
      pipe.push_front(enter);
      void'(pipe.pop_back());
`ifdef STALL_CNT_EN
      if (st && exp_cnt < 16'hFFFF) exp_cnt++;
`endif
      #1;
   endtask

   task automatic drain();
      repeat (3) begin
         drive(nop, 1'b0);
         model_check("drain");
         tick();
      end
   endtask

   initial begin
      nop = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      rst_i = 1'b0;
      model_reset();

      // Reset state, with a writer already presented so the first edge after release loads it.
      drive(mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0), 1'b0);
      check("rst_fwdA",  {14'd0, fwdA_sel_o}, 16'd0);
      check("rst_fwdB",  {14'd0, fwdB_sel_o}, 16'd0);
      check("rst_stall", {15'd0, stall_o},    16'd0);
`ifdef STALL_CNT_EN
      check("rst_cnt", stall_cnt_o, 16'd0);
`endif
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();

      // Back-to-back: add r3 then add reading r3 as rs.
      drive(mk(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0), 1'b0);
      model_check("b2b_id");
      check("b2b_stall", {15'd0, stall_o}, 16'd0);
      tick();
      drive(nop, 1'b0);
      model_check("b2b_ex");
      check("b2b_fwdA", {14'd0, fwdA_sel_o}, 16'd1);
      tick();
      drain();

      // Distance-2: r5 written, independent op, then read r5 as rt.
      drive(mk(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0), 1'b0); model_check("d2_w"); tick();
      drive(mk(1'b1, 5'd9, 5'd10, 5'd8, 1'b1, 1'b0), 1'b0); model_check("d2_i"); tick();
      drive(mk(1'b1, 5'd1, 5'd5, 5'd11, 1'b1, 1'b0), 1'b0); model_check("d2_r"); tick();
      drive(nop, 1'b0);
      model_check("d2_ex");
      check("d2_fwdB", {14'd0, fwdB_sel_o}, 16'd2);
      check("d2_fwdA", {14'd0, fwdA_sel_o}, 16'd0);
      tick();
      drain();

      // Double hit: r4 written twice, then read -> younger (MEM) wins.
      drive(mk(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0), 1'b0); model_check("dh_w1"); tick();
      drive(mk(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0), 1'b0); model_check("dh_w2"); tick();
      drive(mk(1'b1, 5'd4, 5'd0, 5'd13, 1'b1, 1'b0), 1'b0); model_check("dh_r"); tick();
      drive(nop, 1'b0);
      model_check("dh_ex");
      check("dh_fwdA", {14'd0, fwdA_sel_o}, 16'd1);
      tick();
      drain();

      // Load-use: lw r7 then add reading r7.
`ifdef STALL_CNT_EN
      check("lu_cnt0", stall_cnt_o, 16'd0);
`endif
      drive(mk(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1), 1'b0); model_check("lu_lw"); tick();
      drive(mk(1'b1, 5'd7, 5'd3, 5'd12, 1'b1, 1'b0), 1'b0);
      model_check("lu_hz");
      check("lu_stall1", {15'd0, stall_o}, 16'd1);
      tick();
      drive(mk(1'b1, 5'd7, 5'd3, 5'd12, 1'b1, 1'b0), 1'b0);
      model_check("lu_bub");
      check("lu_stall0",   {15'd0, stall_o},    16'd0);
      check("lu_bub_fwdA", {14'd0, fwdA_sel_o}, 16'd0);
`ifdef STALL_CNT_EN
      check("lu_cnt1", stall_cnt_o, 16'd1);
`endif
      tick();
      drive(nop, 1'b0);
      model_check("lu_ex");
      check("lu_fwdA", {14'd0, fwdA_sel_o}, 16'd2);
      tick();
      drain();

      // r0 destination is never forwarded.
      drive(mk(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0), 1'b0); model_check("r0_w"); tick();
      drive(mk(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0), 1'b0); model_check("r0_r"); tick();
      drive(nop, 1'b0);
      model_check("r0_ex");
      check("r0_fwdA", {14'd0, fwdA_sel_o}, 16'd0);
      check("r0_fwdB", {14'd0, fwdB_sel_o}, 16'd0);
      tick();

      // Flushed writer leaves nothing to forward.
      drive(mk(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0), 1'b1); model_check("fl_w"); tick();
      drive(mk(1'b1, 5'd9, 5'd9, 5'd15, 1'b1, 1'b0), 1'b0); model_check("fl_r"); tick();
      drive(nop, 1'b0);
      model_check("fl_ex");
      check("fl_fwdA", {14'd0, fwdA_sel_o}, 16'd0);
      check("fl_fwdB", {14'd0, fwdB_sel_o}, 16'd0);
      tick();
      drain();

      // Flush together with a load-use stall inserts a single bubble.
      drive(mk(1'b1, 5'd2, 5'd0, 5'd13, 1'b1, 1'b1), 1'b0); model_check("fs_lw"); tick();
      drive(mk(1'b1, 5'd13, 5'd1, 5'd16, 1'b1, 1'b0), 1'b1);
      model_check("fs_hz");
      check("fs_stall1", {15'd0, stall_o}, 16'd1);
      tick();
      drive(mk(1'b1, 5'd13, 5'd1, 5'd16, 1'b1, 1'b0), 1'b0);
      model_check("fs_bub");
      check("fs_stall0", {15'd0, stall_o}, 16'd0);
      tick();
      drive(nop, 1'b0);
      model_check("fs_ex");
      check("fs_fwdA", {14'd0, fwdA_sel_o}, 16'd2);
      tick();
      drain();

      // Random traffic on a small register range so hazards are frequent; stalled instructions are held.
      held = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic fl;
         if (!held) begin
            cur_ins.v  = ($urandom_range(0, 7) != 0);
            cur_ins.rs = 5'($urandom_range(0, 7));
            cur_ins.rt = 5'($urandom_range(0, 7));
            cur_ins.rd = 5'($urandom_range(0, 7));
            cur_ins.ld = ($urandom_range(0, 3) == 0);
            cur_ins.we = cur_ins.ld | 1'($urandom_range(0, 1));
         end
         fl = ($urandom_range(0, 7) == 0);
         drive(cur_ins, fl);
         model_check("rnd");
         held = exp_stall();
         tick();
      end
      drain();

      // Async reset during a stall with live forwarding.
      drive(mk(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0), 1'b0); model_check("ar_w"); tick();
      drive(mk(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b1), 1'b0); model_check("ar_lw"); tick();
      drive(mk(1'b1, 5'd7, 5'd1, 5'd12, 1'b1, 1'b0), 1'b0);
      model_check("ar_hz");
      check("ar_pre_stall", {15'd0, stall_o}, 16'd1);
      rst_i = 1'b0;
      #1;
      check("ar_stall", {15'd0, stall_o},    16'd0);
      check("ar_fwdA",  {14'd0, fwdA_sel_o}, 16'd0);
      check("ar_fwdB",  {14'd0, fwdB_sel_o}, 16'd0);
`ifdef STALL_CNT_EN
      check("ar_cnt", stall_cnt_o, 16'd0);
`endif
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();
      drive(nop, 1'b0);
      model_check("ar_post");
      tick();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
